// File: rtl/rptr_handler.sv
// ----------------------------------------------------------------------------
// rptr_handler
//   Read-domain pointer controller for an asynchronous FIFO. Brings the Gray
//   write pointer into the read clock domain through a two-flop synchronizer,
//   advances the binary/Gray read pointers on accepted reads and produces
//   registered status flags.
//
// Parameters
//   PTR_WIDTH       : address width; pointers carry one extra wrap bit
//   ALMOST_EMPTY_TH : almost_empty asserts when level <= this value
//
// Ports
//   rclk         in   read-domain clock
//   rrst         in   asynchronous active-high reset
//   r_en         in   read request
//   g_wptr       in   Gray write pointer (asynchronous to rclk)
//   b_rptr       out  binary read pointer; low PTR_WIDTH bits = memory address
//   g_rptr       out  Gray read pointer, handed to the write domain
//   empty        out  FIFO empty (registered)
//   almost_empty out  level <= ALMOST_EMPTY_TH (registered)
//   rd_level     out  entries available as seen in the read domain
//   r_valid      out  memory read data valid this cycle
//   underflow    out  sticky: read attempted while empty
// ----------------------------------------------------------------------------
module rptr_handler #(
   parameter int PTR_WIDTH       = 3,
   parameter int ALMOST_EMPTY_TH = 1
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic                 r_en,
   input  logic [PTR_WIDTH:0]   g_wptr,
   output logic [PTR_WIDTH:0]   b_rptr,
   output logic [PTR_WIDTH:0]   g_rptr,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [PTR_WIDTH:0]   rd_level,
   output logic                 r_valid,
   output logic                 underflow
);

   localparam logic [PTR_WIDTH:0] AE_TH = (PTR_WIDTH+1)'(ALMOST_EMPTY_TH);

   logic [PTR_WIDTH:0] s1;
   logic [PTR_WIDTH:0] g_wptr_sync;
   logic [PTR_WIDTH:0] b_wptr_sync;
   logic [PTR_WIDTH:0] b_rptr_next;
   logic [PTR_WIDTH:0] g_rptr_next;
   logic [PTR_WIDTH:0] lvl_next;
   logic               accepted;

   // Two-flop synchronizer: the only logic that samples g_wptr.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         s1          <= '0;
         g_wptr_sync <= '0;
      end else begin
         s1          <= g_wptr;
         g_wptr_sync <= s1;
      end
   end

   // Gray to binary: bit i is the XOR of all bits at or above i.
   always_comb begin
      b_wptr_sync = '0;
      for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
         b_wptr_sync[i] = ^(g_wptr_sync >> i);
      end
   end

   always_comb begin
      accepted    = r_en & ~empty;
      b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, accepted};
      g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;
      // Modular difference stays correct across pointer wrap.
      lvl_next    = b_wptr_sync - b_rptr_next;
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         b_rptr       <= '0;
         g_rptr       <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= '0;
         r_valid      <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         b_rptr       <= b_rptr_next;
         g_rptr       <= g_rptr_next;
         // Compare against the already-advanced pointer so the last read
         // sets empty on the same edge and blocks a read on the next one.
         empty        <= (g_rptr_next == g_wptr_sync);
         almost_empty <= (lvl_next <= AE_TH);
         rd_level     <= lvl_next;
         r_valid      <= accepted;
         underflow    <= underflow | (r_en & empty);
      end
   end

endmodule

// File: tb/tb_rptr_handler.sv
// ----------------------------------------------------------------------------
// tb_rptr_handler
//   Self-checking bench for rptr_handler. A count-based reference model
//   (integer write/read counts, two-deep history of the write count for the
//   synchronizer) predicts every output each cycle; directed phases add
//   fixed-value checks for the key scenarios, then random traffic follows.
// ----------------------------------------------------------------------------
module tb_rptr_handler;

   localparam int PW   = 3;
   localparam int TH   = 1;
   localparam int MASK = (1 << (PW + 1)) - 1;

   logic          rclk = 1'b0;
   logic          rrst = 1'b0;
   logic          r_en = 1'b0;
   logic [PW:0]   g_wptr = '0;
   logic [PW:0]   b_rptr;
   logic [PW:0]   g_rptr;
   logic          empty;
   logic          almost_empty;
   logic [PW:0]   rd_level;
   logic          r_valid;
   logic          underflow;

   rptr_handler #(.PTR_WIDTH(PW), .ALMOST_EMPTY_TH(TH)) dut (
      .rclk         (rclk),
      .rrst         (rrst),
      .r_en         (r_en),
      .g_wptr       (g_wptr),
      .b_rptr       (b_rptr),
      .g_rptr       (g_rptr),
      .empty        (empty),
      .almost_empty (almost_empty),
      .rd_level     (rd_level),
      .r_valid      (r_valid),
      .underflow    (underflow)
   );

   always #5 rclk = ~rclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: counts of writes/reads, synchronizer history.
   int w, m_r, m_s1, m_s2, m_lvl, n_acc;
   bit m_empty, m_ae, m_valid, m_uf;

   function automatic logic [PW:0] gray(input int v);
      logic [PW:0] b;
      b = (PW+1)'(v & MASK);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_model();
      chk("b_rptr",       32'(b_rptr),       32'(m_r & MASK));
      chk("g_rptr",       32'(g_rptr),       32'(gray(m_r)));
      chk("empty",        32'(empty),        32'(m_empty));
      chk("almost_empty", 32'(almost_empty), 32'(m_ae));
      chk("rd_level",     32'(rd_level),     32'(m_lvl));
      chk("r_valid",      32'(r_valid),      32'(m_valid));
      chk("underflow",    32'(underflow),    32'(m_uf));
   endtask

   // One clock: apply inputs, advance model at the edge, check at negedge.
   task automatic step(input bit re, input bit winc);
      bit acc;
      r_en = re;
      if (winc) w++;
      g_wptr = gray(w);
      @(posedge rclk);
      acc = re && !m_empty;
      if (re && m_empty) m_uf = 1'b1;
      m_r    += int'(acc);
      m_lvl   = (m_s2 - m_r) & MASK;
      m_empty = (m_lvl == 0);
      m_ae    = (m_lvl <= TH);
      m_valid = acc;
      m_s2    = m_s1;
      m_s1    = w;
      if (acc) n_acc++;
      @(negedge rclk);
      check_model();
   endtask

   // Asynchronous reset pulse issued between clock edges.
   task automatic do_reset(input bit clear_w);
      rrst = 1'b1;
      if (clear_w) begin
         w = 0;
         g_wptr = '0;
      end
      #1;
      chk("rst_b_rptr",    32'(b_rptr),       32'd0);
      chk("rst_g_rptr",    32'(g_rptr),       32'd0);
      chk("rst_empty",     32'(empty),        32'd1);
      chk("rst_ae",        32'(almost_empty), 32'd1);
      chk("rst_level",     32'(rd_level),     32'd0);
      chk("rst_valid",     32'(r_valid),      32'd0);
      chk("rst_underflow", 32'(underflow),    32'd0);
      m_r = 0; m_s1 = 0; m_s2 = 0; m_lvl = 0;
      m_empty = 1'b1; m_ae = 1'b1; m_valid = 1'b0; m_uf = 1'b0;
      n_acc = 0;
      #2;
      rrst = 1'b0;
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      w = 0;
      @(negedge rclk);

      // Reset
      do_reset(1'b1);
      step(1'b0, 1'b0);

      // Single entry: visible on the third edge after the write pointer moves
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk("single_not_yet", 32'(empty), 32'd1);
      step(1'b0, 1'b0);
      chk("single_empty0", 32'(empty), 32'd0);
      chk("single_level1", 32'(rd_level), 32'd1);
      step(1'b1, 1'b0);
      chk("single_b_rptr", 32'(b_rptr), 32'd1);
      chk("single_g_rptr", 32'(g_rptr), 32'b0001);
      chk("single_valid",  32'(r_valid), 32'd1);
      chk("single_empty1", 32'(empty), 32'd1);

      // Full drain
      do_reset(1'b1);
      fill(8);
      chk("drain_level8", 32'(rd_level), 32'd8);
      chk("drain_ae0",    32'(almost_empty), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         if (i < 8) chk("drain_level", 32'(rd_level), 32'(7 - i));
         if (i == 6) chk("drain_ae_at1", 32'(almost_empty), 32'd1);
         if (i == 7) chk("drain_empty", 32'(empty), 32'd1);
         if (i == 8) chk("drain_uf", 32'(underflow), 32'd1);
      end
      chk("drain_accepts", 32'(n_acc), 32'd8);

      // Wrap-around: three fill/drain rounds
      do_reset(1'b1);
      for (int k = 0; k < 3; k++) begin
         fill(8);
         for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      end
      chk("wrap_accepts", 32'(n_acc), 32'd24);
      chk("wrap_b_rptr",  32'(b_rptr), 32'd8);
      chk("wrap_g_rptr",  32'(g_rptr), 32'b1100);
      chk("wrap_empty",   32'(empty), 32'd1);

      // Last entry read as a new synchronized write arrives
      do_reset(1'b1);
      fill(1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("simul_valid", 32'(r_valid), 32'd1);
      chk("simul_empty", 32'(empty), 32'd0);
      chk("simul_level", 32'(rd_level), 32'd1);

      // Reset mid-drain with r_en held high
      do_reset(1'b1);
      fill(8);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      chk("midrst_no_accept", 32'(n_acc), 32'd0);
      chk("midrst_level", 32'(rd_level), 32'd8);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      chk("midrst_resume", 32'(n_acc), 32'd4);

      // Random traffic
      do_reset(1'b1);
      for (int i = 0; i < 2000; i++) begin
         bit re, wi;
         re = ($urandom_range(0, 99) < 45);
         wi = ($urandom_range(0, 99) < 50) && ((w - m_r) < 8);
         step(re, wi);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
